// File: rtl/core_pkg.sv
// Shared definitions for the RV32I multi-cycle core: sequencer state encoding
// and the opcode/ALU constants used by the decoder and ALU.
package core_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } seq_state_t;

    localparam logic [6:0] OPC_RTYPE   = 7'h33;
    localparam logic [6:0] OPC_ITYPE   = 7'h13;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

endpackage

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer: owns the PC, handshakes with
// instruction memory, and halts on illegal instructions or fetch timeout.
module core_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_addr,
    input  logic        dec_illegal,
    input  logic        exec_stall,
    output logic        rf_we,
    output logic        halted,
    output logic        fault,
    output logic [31:0] retire_count,
    output logic [2:0]  state_o
);

    seq_state_t  r_state;
    seq_state_t  w_next;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_inst_addr;
    logic [31:0] r_retire;
    logic [7:0]  r_cnt;
    logic        r_fault;
    logic        w_timeout;

    // Timeout fires on the last permitted FETCH cycle; a valid in that cycle still wins.
    assign w_timeout = (r_cnt == 8'(IMEM_TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH: begin
                if (imem_valid)     w_next = S_DECODE;
                else if (w_timeout) w_next = S_HALT;
            end
            S_DECODE: w_next = dec_illegal ? S_HALT : S_EXEC;
            S_EXEC:   if (!exec_stall) w_next = S_WB;
            S_WB:     w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_inst      <= 32'h0;
            r_inst_addr <= RESET_PC;
            r_retire    <= 32'h0;
            r_cnt       <= 8'h0;
            r_fault     <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_FETCH: begin
                    if (imem_valid) begin
                        r_inst      <= imem_rdata;
                        r_inst_addr <= r_pc;
                        r_cnt       <= 8'h0;
                    end else if (w_timeout) begin
                        r_fault <= 1'b1;
                        r_cnt   <= 8'h0;
                    end else begin
                        r_cnt <= r_cnt + 8'h1;
                    end
                end
                S_WB: begin
                    r_pc     <= r_pc + 32'd4;
                    r_retire <= r_retire + 32'd1;
                end
                default: ;
            endcase
        end
    end

    // Handshake and write strobes decode the registered state only.
    assign imem_req     = (r_state == S_FETCH);
    assign rf_we        = (r_state == S_WB);
    assign halted       = (r_state == S_HALT);
    assign imem_addr    = r_pc;
    assign inst         = r_inst;
    assign inst_addr    = r_inst_addr;
    assign fault        = r_fault;
    assign retire_count = r_retire;
    assign state_o      = r_state;

endmodule
